// File: rtl/pio_bank_if.sv
// Avalon-MM slave bus and interrupt line for the PIO bank.
//   avs_address   word address (8 registers)
//   avs_read      read strobe, data returned one cycle later
//   avs_write     write strobe
//   avs_writedata write data
//   avs_readdata  registered read data, held until the next read
//   irq           level interrupt, active high
interface pio_bank_if;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, irq
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, irq
    );
endinterface

// File: rtl/pio_bank_ctrl.sv
// Parallel-I/O bank: debounced inputs with edge capture and maskable IRQ,
// outputs with atomic set/clear, all behind an Avalon-MM register map.
//   clk_clk      system clock
//   reset_reset  synchronous active-high reset
//   bus          Avalon-MM slave (address/read/write/writedata/readdata/irq)
//   in_export    raw asynchronous pin inputs
//   out_export   output pins, driven straight from DATA_OUT
module pio_bank_ctrl #(
    parameter int unsigned IN_WIDTH        = 6,
    parameter int unsigned OUT_WIDTH       = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic [OUT_WIDTH-1:0] OUT_RESET = '0
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    pio_bank_if.slave            bus,
    input  logic [IN_WIDTH-1:0]  in_export,
    output logic [OUT_WIDTH-1:0] out_export
);

    localparam int unsigned PW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [2:0] A_DATA_IN  = 3'd0;
    localparam logic [2:0] A_DATA_OUT = 3'd1;
    localparam logic [2:0] A_OUT_SET  = 3'd2;
    localparam logic [2:0] A_OUT_CLR  = 3'd3;
    localparam logic [2:0] A_IRQ_MASK = 3'd4;
    localparam logic [2:0] A_EDGE_CAP = 3'd5;
    localparam logic [2:0] A_EDGE_CFG = 3'd6;

    localparam logic [31:0] ID_VALUE = {8'h50, 8'(OUT_WIDTH), 8'(IN_WIDTH), 8'h01};

    logic [PW-1:0]        presc;
    logic                 tick;
    logic [IN_WIDTH-1:0]  sync1, sync2;
    logic [IN_WIDTH-1:0]  hist0, hist1;
    logic [IN_WIDTH-1:0]  debounced;
    logic [IN_WIDTH-1:0]  edge_cap;
    logic [IN_WIDTH-1:0]  mask;
    logic [IN_WIDTH-1:0]  cfg_rise, cfg_fall;
    logic [OUT_WIDTH-1:0] data_out;
    logic [31:0]          rdata;
    logic                 irq_q;

    logic [IN_WIDTH-1:0]  agree, db_next, rise, fall, cap_clr, cap_next;
    logic [IN_WIDTH-1:0]  wr_in, wr_fall;
    logic [OUT_WIDTH-1:0] wr_out, out_next;
    logic [31:0]          rd_mux;
    logic                 wr_en;

    assign tick   = (presc == PW'(DEBOUNCE_CYCLES - 1));
    assign wr_en  = bus.avs_write;
    assign wr_in  = bus.avs_writedata[IN_WIDTH-1:0];
    assign wr_fall = bus.avs_writedata[16 +: IN_WIDTH];
    assign wr_out = bus.avs_writedata[OUT_WIDTH-1:0];

    // Debounce decision and edge detection; a set always beats a W1C clear.
    always_comb begin
        agree    = ~(sync2 ^ hist0) & ~(sync2 ^ hist1);
        db_next  = debounced;
        if (tick) begin
            db_next = (debounced & ~agree) | (sync2 & agree);
        end
        rise     = db_next & ~debounced & cfg_rise;
        fall     = ~db_next & debounced & cfg_fall;
        cap_clr  = '0;
        if (wr_en && (bus.avs_address == A_EDGE_CAP)) begin
            cap_clr = wr_in;
        end
        cap_next = (edge_cap & ~cap_clr) | rise | fall;
    end

    // DATA_OUT update including atomic set/clear aliases.
    always_comb begin
        out_next = data_out;
        if (wr_en) begin
            case (bus.avs_address)
                A_DATA_OUT: out_next = wr_out;
                A_OUT_SET:  out_next = data_out | wr_out;
                A_OUT_CLR:  out_next = data_out & ~wr_out;
                default:    out_next = data_out;
            endcase
        end
    end

    // Read mux; reflects pre-write state since it uses current registers.
    always_comb begin
        rd_mux = '0;
        case (bus.avs_address)
            A_DATA_IN:  rd_mux = 32'(debounced);
            A_DATA_OUT,
            A_OUT_SET,
            A_OUT_CLR:  rd_mux = 32'(data_out);
            A_IRQ_MASK: rd_mux = 32'(mask);
            A_EDGE_CAP: rd_mux = 32'(edge_cap);
            A_EDGE_CFG: rd_mux = {16'(cfg_fall), 16'(cfg_rise)};
            default:    rd_mux = ID_VALUE;
        endcase
    end

    // Input path: synchroniser, prescaler and sample history.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1     <= '0;
            sync2     <= '0;
            presc     <= '0;
            hist0     <= '0;
            hist1     <= '0;
            debounced <= '0;
        end else begin
            sync1     <= in_export;
            sync2     <= sync1;
            presc     <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                hist0 <= sync2;
                hist1 <= hist0;
            end
            debounced <= db_next;
        end
    end

    // Register file, read data and interrupt.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            data_out <= OUT_RESET;
            mask     <= '0;
            cfg_rise <= '0;
            cfg_fall <= '0;
            edge_cap <= '0;
            rdata    <= '0;
            irq_q    <= 1'b0;
        end else begin
            data_out <= out_next;
            edge_cap <= cap_next;
            if (wr_en && (bus.avs_address == A_IRQ_MASK)) begin
                mask <= wr_in;
            end
            if (wr_en && (bus.avs_address == A_EDGE_CFG)) begin
                cfg_rise <= wr_in;
                cfg_fall <= wr_fall;
            end
            if (bus.avs_read) begin
                rdata <= rd_mux;
            end
            irq_q <= |(edge_cap & mask);
        end
    end

    assign out_export       = data_out;
    assign bus.avs_readdata = rdata;
    assign bus.irq          = irq_q;

    // Upper write-data bits beyond the configured widths are intentionally dropped.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, bus.avs_writedata};

endmodule
